// File: rtl/rob_flush_sequencer.sv
// Picks the oldest branch mispredict relative to the ROB head, then issues a
// one-cycle rollback pulse to the ROB followed by a dispatch-stall drain window.
module rob_flush_sequencer #(
    parameter int DEPTH        = 16,
    parameter int IDX_W        = $clog2(DEPTH),
    parameter int NUM_BR       = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NUM_BR-1:0]       i_br_valid,
    input  logic [NUM_BR-1:0]       i_br_mispredict,
    input  logic [NUM_BR*IDX_W-1:0] i_br_rob_idx,
    input  logic [IDX_W-1:0]        i_rob_head_idx,
    input  logic                    i_commit_en,
    output logic                    o_branch_mispredict,
    output logic [IDX_W-1:0]        o_recovery_idx,
    output logic                    o_dispatch_stall,
    output logic                    o_busy,
    output logic [CNT_W-1:0]        o_flush_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    state_t                  r_state;
    logic [IDX_W-1:0]        r_cur_idx;
    logic [3:0]              r_cnt;
    logic                    r_committed;
    logic                    r_branch_mispredict;
    logic [IDX_W-1:0]        r_recovery_idx;
    logic                    r_dispatch_stall;
    logic                    r_busy;
    logic [CNT_W-1:0]        r_flush_count;

    logic [IDX_W-1:0]        w_idx [NUM_BR];
    logic [IDX_W-1:0]        w_age [NUM_BR];
    logic [NUM_BR-1:0]       w_cand;
    logic                    w_any;
    logic [IDX_W-1:0]        w_win_idx;
    logic [IDX_W-1:0]        w_win_age;
    logic [IDX_W-1:0]        w_cur_age;
    logic                    w_preempt;
    logic                    w_go_flush;

    // Age is the modular distance from the head, so wrap-around needs no special case.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BR; gi++) begin : g_port
            assign w_idx[gi]  = i_br_rob_idx[gi*IDX_W +: IDX_W];
            assign w_age[gi]  = w_idx[gi] - i_rob_head_idx;
            assign w_cand[gi] = i_br_valid[gi] & i_br_mispredict[gi];
        end
    endgenerate

    // Strict less-than keeps the lowest port on an age tie.
    always_comb begin
        w_any     = 1'b0;
        w_win_idx = '0;
        w_win_age = '0;
        for (int i = 0; i < NUM_BR; i++) begin
            if (w_cand[i] && (!w_any || (w_age[i] < w_win_age))) begin
                w_any     = 1'b1;
                w_win_idx = w_idx[i];
                w_win_age = w_age[i];
            end
        end
    end

    assign w_cur_age  = r_cur_idx - i_rob_head_idx;
    assign w_preempt  = w_any && !r_committed && (w_win_age < w_cur_age);
    assign w_go_flush = (r_state == ST_IDLE) ? w_any : w_preempt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state             <= ST_IDLE;
            r_cur_idx           <= '0;
            r_cnt               <= '0;
            r_committed         <= 1'b0;
            r_branch_mispredict <= 1'b0;
            r_recovery_idx      <= '0;
            r_dispatch_stall    <= 1'b0;
            r_busy              <= 1'b0;
            r_flush_count       <= '0;
        end else begin
            // Once the recovering branch has committed its age is meaningless; lock out preemption.
            if ((r_state != ST_IDLE) && i_commit_en && (i_rob_head_idx == r_cur_idx)) begin
                r_committed <= 1'b1;
            end

            if (w_go_flush) begin
                r_state             <= ST_FLUSH;
                r_cur_idx           <= w_win_idx;
                r_committed         <= 1'b0;
                r_branch_mispredict <= 1'b1;
                r_recovery_idx      <= w_win_idx;
                r_dispatch_stall    <= 1'b1;
                r_busy              <= 1'b1;
                r_flush_count       <= r_flush_count + 1'b1;
            end else begin
                case (r_state)
                    ST_FLUSH: begin
                        r_branch_mispredict <= 1'b0;
                        if (DRAIN_INIT == 4'd0) begin
                            r_state          <= ST_IDLE;
                            r_dispatch_stall <= 1'b0;
                            r_busy           <= 1'b0;
                        end else begin
                            r_state <= ST_DRAIN;
                            r_cnt   <= DRAIN_INIT;
                        end
                    end
                    ST_DRAIN: begin
                        r_branch_mispredict <= 1'b0;
                        if (r_cnt <= 4'd1) begin
                            r_state          <= ST_IDLE;
                            r_cnt            <= '0;
                            r_dispatch_stall <= 1'b0;
                            r_busy           <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                    default: begin
                        r_state             <= ST_IDLE;
                        r_branch_mispredict <= 1'b0;
                        r_dispatch_stall    <= 1'b0;
                        r_busy              <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_branch_mispredict = r_branch_mispredict;
    assign o_recovery_idx      = r_recovery_idx;
    assign o_dispatch_stall    = r_dispatch_stall;
    assign o_busy              = r_busy;
    assign o_flush_count       = r_flush_count;

endmodule

// File: tb/tb_rob_flush_sequencer.sv
// Directed bench for rob_flush_sequencer: cycle-by-cycle vector table plus
// hand sequences for async reset and a zero-drain / narrow-counter instance.
module tb_rob_flush_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_valid;
    logic [1:0] br_mispredict;
    logic [7:0] br_rob_idx;
    logic [3:0] rob_head_idx;
    logic       commit_en;

    logic       a_bm, a_stall, a_busy;
    logic [3:0] a_ridx;
    logic [15:0] a_fc;
    logic       b_bm, b_stall, b_busy;
    logic [3:0] b_ridx;
    logic [1:0] b_fc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rob_flush_sequencer #(.DEPTH(16), .IDX_W(4), .NUM_BR(2), .DRAIN_CYCLES(3), .CNT_W(16)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_br_valid(br_valid), .i_br_mispredict(br_mispredict),
        .i_br_rob_idx(br_rob_idx), .i_rob_head_idx(rob_head_idx), .i_commit_en(commit_en),
        .o_branch_mispredict(a_bm), .o_recovery_idx(a_ridx), .o_dispatch_stall(a_stall),
        .o_busy(a_busy), .o_flush_count(a_fc)
    );

    rob_flush_sequencer #(.DEPTH(16), .IDX_W(4), .NUM_BR(2), .DRAIN_CYCLES(0), .CNT_W(2)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_br_valid(br_valid), .i_br_mispredict(br_mispredict),
        .i_br_rob_idx(br_rob_idx), .i_rob_head_idx(rob_head_idx), .i_commit_en(commit_en),
        .o_branch_mispredict(b_bm), .o_recovery_idx(b_ridx), .o_dispatch_stall(b_stall),
        .o_busy(b_busy), .o_flush_count(b_fc)
    );

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  m;
        logic [3:0]  i0;
        logic [3:0]  i1;
        logic [3:0]  head;
        logic        ce;
        logic        bm;
        logic [3:0]  ridx;
        logic        rchk;
        logic        stall;
        logic        busy;
        logic [15:0] fc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] v, input logic [1:0] m, input logic [3:0] i0,
                       input logic [3:0] i1, input logic [3:0] head, input logic ce,
                       input logic bm, input logic [3:0] ridx, input logic rchk,
                       input logic stall, input logic busy, input logic [15:0] fc);
        vec_t t;
        t.v = v; t.m = m; t.i0 = i0; t.i1 = i1; t.head = head; t.ce = ce;
        t.bm = bm; t.ridx = ridx; t.rchk = rchk; t.stall = stall; t.busy = busy; t.fc = fc;
        vecs.push_back(t);
    endtask

    // Quiet cycle inside a drain window.
    task automatic add_drain(input logic [3:0] head, input logic [3:0] ridx, input logic [15:0] fc);
        add(2'b00, 2'b00, 4'd0, 4'd0, head, 1'b0, 1'b0, ridx, 1'b1, 1'b1, 1'b1, fc);
    endtask

    task automatic add_idle(input logic [3:0] head, input logic [15:0] fc);
        add(2'b00, 2'b00, 4'd0, 4'd0, head, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, fc);
    endtask

    task automatic chk(input string nm, input int vi, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", nm, vi, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] m, input logic [3:0] i0,
                         input logic [3:0] i1, input logic [3:0] head, input logic ce);
        br_valid      = v;
        br_mispredict = m;
        br_rob_idx    = {i1, i0};
        rob_head_idx  = head;
        commit_en     = ce;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 1'b0);

        // Idle, plus a correctly-predicted resolution that must be ignored.
        for (int k = 0; k < 20; k++)
            add(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'd0);
        add(2'b11, 2'b00, 4'd5, 4'd6, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'd0);
        // Basic flush, head=0, idx=5: pulse then three drain cycles.
        add(2'b01, 2'b01, 4'd5, 4'd0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 16'd1);
        for (int k = 0; k < 3; k++) add_drain(4'd0, 4'd5, 16'd1);
        add_idle(4'd0, 16'd1);
        // Wrap-around: head=14, idx1 age 3, idx15 age 1.
        add(2'b11, 2'b11, 4'd1, 4'd15, 4'd14, 1'b0, 1'b1, 4'd15, 1'b1, 1'b1, 1'b1, 16'd2);
        for (int k = 0; k < 3; k++) add_drain(4'd14, 4'd15, 16'd2);
        add_idle(4'd14, 16'd2);
        // Same idx on both ports yields one pulse.
        add(2'b11, 2'b11, 4'd7, 4'd7, 4'd14, 1'b0, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 16'd3);
        for (int k = 0; k < 3; k++) add_drain(4'd14, 4'd7, 16'd3);
        add_idle(4'd14, 16'd3);
        // Preemption during drain by an older branch restarts the window.
        add(2'b01, 2'b01, 4'd8, 4'd0, 4'd0, 1'b0, 1'b1, 4'd8, 1'b1, 1'b1, 1'b1, 16'd4);
        add_drain(4'd0, 4'd8, 16'd4);
        add(2'b10, 2'b10, 4'd0, 4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 16'd5);
        for (int k = 0; k < 3; k++) add_drain(4'd0, 4'd3, 16'd5);
        add_idle(4'd0, 16'd5);
        // Younger report during drain is already squashed.
        add(2'b01, 2'b01, 4'd8, 4'd0, 4'd0, 1'b0, 1'b1, 4'd8, 1'b1, 1'b1, 1'b1, 16'd6);
        add_drain(4'd0, 4'd8, 16'd6);
        add(2'b10, 2'b10, 4'd0, 4'd10, 4'd0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b1, 1'b1, 16'd6);
        add_drain(4'd0, 4'd8, 16'd6);
        add_idle(4'd0, 16'd6);
        // Older report in the same cycle as the pulse: back-to-back pulses.
        add(2'b01, 2'b01, 4'd8, 4'd0, 4'd0, 1'b0, 1'b1, 4'd8, 1'b1, 1'b1, 1'b1, 16'd7);
        add(2'b10, 2'b10, 4'd0, 4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 16'd8);
        for (int k = 0; k < 3; k++) add_drain(4'd0, 4'd3, 16'd8);
        add_idle(4'd0, 16'd8);
        // Committed branch locks out reports until idle; the held report then fires.
        add(2'b01, 2'b01, 4'd2, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 16'd9);
        add(2'b00, 2'b00, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 16'd9);
        add(2'b01, 2'b01, 4'd6, 4'd0, 4'd3, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 16'd9);
        add(2'b01, 2'b01, 4'd6, 4'd0, 4'd3, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 16'd9);
        add(2'b01, 2'b01, 4'd6, 4'd0, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'd9);
        add(2'b01, 2'b01, 4'd6, 4'd0, 4'd3, 1'b0, 1'b1, 4'd6, 1'b1, 1'b1, 1'b1, 16'd10);
        for (int k = 0; k < 3; k++) add_drain(4'd3, 4'd6, 16'd10);
        add_idle(4'd3, 16'd10);

        step;
        step;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_bm", -1, 32'(a_bm), 32'd0);
        chk("reset_ridx", -1, 32'(a_ridx), 32'd0);
        chk("reset_stall", -1, 32'(a_stall), 32'd0);
        chk("reset_busy", -1, 32'(a_busy), 32'd0);
        chk("reset_fc", -1, 32'(a_fc), 32'd0);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].v, vecs[k].m, vecs[k].i0, vecs[k].i1, vecs[k].head, vecs[k].ce);
            step;
            chk("vec_bm", k, 32'(a_bm), 32'(vecs[k].bm));
            if (vecs[k].rchk) chk("vec_ridx", k, 32'(a_ridx), 32'(vecs[k].ridx));
            chk("vec_stall", k, 32'(a_stall), 32'(vecs[k].stall));
            chk("vec_busy", k, 32'(a_busy), 32'(vecs[k].busy));
            chk("vec_fc", k, 32'(a_fc), 32'(vecs[k].fc));
        end

        // Async reset in the middle of a drain window.
        drive(2'b01, 2'b01, 4'd5, 4'd0, 4'd0, 1'b0);
        step;
        chk("ar_pulse", 0, 32'(a_bm), 32'd1);
        chk("ar_fc", 0, 32'(a_fc), 32'd11);
        drive(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 1'b0);
        step;
        chk("ar_drain_stall", 1, 32'(a_stall), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("ar_bm", 2, 32'(a_bm), 32'd0);
        chk("ar_stall", 2, 32'(a_stall), 32'd0);
        chk("ar_busy", 2, 32'(a_busy), 32'd0);
        chk("ar_fc_clr", 2, 32'(a_fc), 32'd0);
        #2 rst = 1'b0;
        step;
        chk("ar_idle_busy", 3, 32'(a_busy), 32'd0);
        chk("ar_idle_stall", 3, 32'(a_stall), 32'd0);
        drive(2'b10, 2'b10, 4'd0, 4'd9, 4'd0, 1'b0);
        step;
        chk("ar_after_bm", 4, 32'(a_bm), 32'd1);
        chk("ar_after_ridx", 4, 32'(a_ridx), 32'd9);
        chk("ar_after_fc", 4, 32'(a_fc), 32'd1);

        // Zero-length drain with a 2-bit counter: a held report pulses every other cycle.
        drive(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 1'b0);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        chk("b_reset_fc", 0, 32'(b_fc), 32'd0);
        chk("b_reset_busy", 0, 32'(b_busy), 32'd0);
        drive(2'b01, 2'b01, 4'd5, 4'd0, 4'd0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step;
            chk("b_bm", k, 32'(b_bm), 32'(k % 2));
            chk("b_stall", k, 32'(b_stall), 32'(k % 2));
            chk("b_busy", k, 32'(b_busy), 32'(k % 2));
            chk("b_fc", k, 32'(b_fc), 32'(((k + 1) / 2) % 4));
            if ((k % 2) == 1) chk("b_ridx", k, 32'(b_ridx), 32'd5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
